// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the RV32 data-memory initiator: funct3 codes,
// memory-port control words, LSU state type and the request legality check.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] MEM_READ_WORD  = 4'b1010;
    localparam logic [2:0] MEM_WRITE_WORD = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } lsu_state_t;

    // A request is rejected without touching memory when its type is ambiguous,
    // its funct3 is not a defined access, or it is not naturally aligned.
    function automatic logic request_illegal(
        input logic       is_load,
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [1:0] offset
    );
        logic bad;
        bad = (is_load == is_store);
        if (is_load) begin
            bad = bad | !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end else begin
            bad = bad | !(funct3 inside {F3_SB, F3_SH, F3_SW});
        end
        if (funct3[1:0] == 2'b01) begin
            bad = bad | offset[0];
        end
        if (funct3[1:0] == 2'b10) begin
            bad = bad | (offset != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling for the LSU: extracts and extends sub-word load data and
// merges sub-word store data into a fetched memory word.
module lsu_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            F3_LW:   load_data = word;
            F3_LBU:  load_data = {24'd0, byte_lane};
            F3_LHU:  load_data = {16'd0, half_lane};
            default: load_data = 32'd0;
        endcase
    end

    // Sub-word stores keep every lane of the fetched word except the one replaced.
    always_comb begin
        store_word = word;
        case (funct3)
            F3_SB: begin
                case (offset)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            F3_SH: begin
                if (offset[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store initiator: word-aligned accesses to data memory, sub-word
// load extension, and read-modify-write for SB/SH.
module load_store_unit
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [3:0]        mem_read,
    output logic [2:0]        mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_busywait
);

    lsu_state_t        state;
    lsu_state_t        next_state;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic              is_load_q;
    logic              err_q;
    logic [31:0]       word_q;
    logic              req_err;
    logic [31:0]       align_word;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign req_err = request_illegal(req_load, req_store, req_funct3, req_addr[1:0]);

    // word_q holds the store data until the read returns, then the merged or loaded word.
    assign align_word = (state == S_READ) ? mem_readdata : word_q;

    lsu_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .word       (align_word),
        .wdata      (word_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            funct3_q  <= 3'd0;
            addr_q    <= '0;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
            word_q    <= 32'd0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        is_load_q <= req_load;
                        err_q     <= req_err;
                        word_q    <= req_wdata;
                    end
                end
                S_READ: begin
                    if (!mem_busywait) begin
                        word_q <= is_load_q ? mem_readdata : store_word;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        next_state = S_DONE;
                    end else if (req_load || (req_funct3 != F3_SW)) begin
                        next_state = S_READ;
                    end else begin
                        next_state = S_WRITE;
                    end
                end
            end
            S_READ: begin
                if (!mem_busywait) begin
                    next_state = is_load_q ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (!mem_busywait) begin
                    next_state = S_DONE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign err           = done & err_q;
    assign rdata         = (done && is_load_q && !err_q) ? load_data : 32'd0;
    assign mem_read      = (state == S_READ)  ? MEM_READ_WORD  : 4'd0;
    assign mem_write     = (state == S_WRITE) ? MEM_WRITE_WORD : 3'd0;
    assign mem_address   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_writedata = word_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word memory slave plus a transaction-level model
// that predicts the per-cycle handshake, load results and memory contents.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];
    logic        mem_preload;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic        txn_active = 1'b0;
    int          t_a = 0;
    int          lat = 0;
    int          nr_q = 0;
    int          nw_q = 0;
    int          wr_off = 0;
    int          cur_idx = 0;
    logic        cur_store = 1'b0;
    logic        has_rd = 1'b0;
    logic        has_wr = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_wword = 32'd0;
    logic [31:0] last_rdata = 32'd0;

    logic [2:0]  load_codes  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  store_codes [3] = '{3'b000, 3'b001, 3'b010};

    load_store_unit dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_load      (req_load),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .busy          (busy),
        .done          (done),
        .rdata         (rdata),
        .err           (err),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'h8899AABB : ((32'h13579BDF * 32'(i + 1)) ^ 32'hA5A50000);
    endfunction

    // Stalls are planned per transaction: the first nr read cycles and nw write cycles wait.
    assign mem_busywait = txn_active &&
        ((has_rd && ((cyc - t_a) < nr_q)) ||
         (has_wr && ((cyc - t_a) >= wr_off) && ((cyc - t_a) < (wr_off + nw_q))));

    assign mem_readdata = mem[mem_address[5:2]];

    always @(posedge clock) begin
        if (mem_preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (mem_write[2] && !mem_busywait) begin
            mem[mem_address[5:2]] <= mem_writedata;
        end
    end

    function automatic logic model_err(input logic ld, input logic st, input logic [2:0] f3,
                                       input logic [31:0] addr);
        int size;
        if (ld == st) return 1'b1;
        if (ld && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
        if (st && (f3 > 3'b010)) return 1'b1;
        size = 1 << f3[1:0];
        return (addr % 32'(size)) != 32'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] s;
        logic [31:0] v;
        s = word >> (32'd8 * 32'(off));
        case (f3)
            3'b000: begin
                v = s & 32'hFF;
                if (v >= 32'd128) v = v - 32'd256;
            end
            3'b001: begin
                v = s & 32'hFFFF;
                if (v >= 32'd32768) v = v - 32'd65536;
            end
            3'b010:  v = word;
            3'b100:  v = s & 32'hFF;
            3'b101:  v = s & 32'hFFFF;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word, input logic [31:0] wdata);
        logic [31:0] mask;
        logic [31:0] sh;
        sh = 32'd8 * 32'(off);
        case (f3)
            3'b000:  mask = 32'hFF << sh;
            3'b001:  mask = 32'hFFFF << sh;
            default: return wdata;
        endcase
        return (word & ~mask) | ((wdata << sh) & mask);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
        checkOutput("rst_mem_address", mem_address, 32'd0);
        checkOutput("rst_mem_writedata", mem_writedata, 32'd0);
    endtask

    // Per-cycle compare against the timeline derived from the current transaction.
    always @(negedge clock) begin : compare
        int   rel;
        logic e_busy;
        logic e_done;
        logic e_rd;
        logic e_wr;
        if (!reset) begin
            rel    = cyc - t_a;
            e_busy = txn_active && (rel < lat);
            e_done = txn_active && (rel == lat - 1);
            e_rd   = txn_active && has_rd && (rel <= nr_q);
            e_wr   = txn_active && has_wr && (rel >= wr_off) && (rel <= wr_off + nw_q);
            checkOutput("busy", 32'(busy), 32'(e_busy));
            checkOutput("done", 32'(done), 32'(e_done));
            checkOutput("err", 32'(err), 32'(e_done && exp_err));
            checkOutput("mem_read", 32'(mem_read), e_rd ? 32'hA : 32'h0);
            checkOutput("mem_write", 32'(mem_write), e_wr ? 32'h6 : 32'h0);
            if (e_done) begin
                last_rdata = rdata;
                checkOutput("rdata", rdata, exp_rdata);
            end
            if (e_rd || e_wr) checkOutput("mem_address", mem_address, exp_addr);
            if (e_wr) checkOutput("mem_writedata", mem_writedata, exp_wword);
        end
    end

    task automatic startTxn(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int nr, input int nw);
        logic [31:0] word;
        int          idx;
        @(negedge clock);
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        idx       = int'(addr[5:2]);
        word      = ref_mem[idx];
        exp_err   = model_err(ld, st, f3, addr);
        has_rd    = !exp_err && (ld || (f3 != 3'b010));
        has_wr    = !exp_err && st;
        nr_q      = has_rd ? nr : 0;
        nw_q      = has_wr ? nw : 0;
        wr_off    = has_rd ? nr_q + 1 : 0;
        if (exp_err)     lat = 1;
        else if (ld)     lat = 2 + nr_q;
        else if (!has_rd) lat = 2 + nw_q;
        else             lat = 3 + nr_q + nw_q;
        exp_addr   = addr & ~32'h3;
        exp_rdata  = (!exp_err && ld) ? model_load(f3, addr[1:0], word) : 32'd0;
        exp_wword  = model_store(f3, addr[1:0], word, wdata);
        cur_idx    = idx;
        cur_store  = has_wr;
        t_a        = cyc;
        txn_active = 1'b1;
    endtask

    task automatic finishTxn();
        repeat (lat) @(posedge clock);
        #1;
        txn_active = 1'b0;
        if (cur_store) begin
            ref_mem[cur_idx] = exp_wword;
            checkOutput("mem_word", mem[cur_idx], ref_mem[cur_idx]);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int nr, input int nw,
                                 input logic pin_en, input logic [31:0] pin_val);
        startTxn(ld, st, f3, addr, wdata, nr, nw);
        finishTxn();
        if (pin_en) begin
            checkOutput("pin_model", exp_rdata, pin_val);
            checkOutput("pin_dut", last_rdata, pin_val);
        end
    endtask

    // SB is aborted by reset while its write is pending; memory must keep the old word.
    task automatic resetDuringWrite();
        startTxn(1'b0, 1'b1, 3'b000, 32'h4, 32'h00000055, 0, 0);
        @(posedge clock);
        @(negedge clock);
        #1;
        reset      = 1'b1;
        txn_active = 1'b0;
        #1;
        checkResetOutputs();
        @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        checkOutput("abort_word", mem[1], ref_mem[1]);
    endtask

    initial begin
        reset       = 1'b1;
        mem_preload = 1'b1;
        req_valid   = 1'b0;
        req_load    = 1'b0;
        req_store   = 1'b0;
        req_funct3  = 3'd0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        repeat (2) @(posedge clock);
        #1;
        checkResetOutputs();
        @(negedge clock);
        reset       = 1'b0;
        mem_preload = 1'b0;

        applyStimulus(1'b1, 1'b0, 3'b000, 32'h5, 32'd0, 0, 0, 1'b1, 32'hFFFFFFAA);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h5, 32'd0, 0, 0, 1'b1, 32'h000000AA);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h6, 32'd0, 0, 0, 1'b1, 32'h00008899);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h6, 32'h00001234, 0, 0, 1'b0, 32'd0);
        checkOutput("sh_merge", mem[1], 32'h1234AABB);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h4, 32'd0, 0, 0, 1'b1, 32'h1234AABB);
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 0, 0, 1'b0, 32'd0);
        checkOutput("sw_word", mem[2], 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h2, 32'd0, 0, 0, 1'b1, 32'd0);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h3, 32'h0000FFFF, 0, 0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h5, 32'd0, 3, 0, 1'b1, 32'hFFFFFFAA);
        resetDuringWrite();
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h4, 32'd0, 0, 0, 1'b1, 32'h1234AABB);

        for (int n = 0; n < 250; n++) begin
            logic        ld;
            logic        st;
            logic [2:0]  f3;
            int          r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                ld = 1'b0;
                st = 1'b0;
            end else if (r == 1) begin
                ld = 1'b1;
                st = 1'b1;
            end else begin
                ld = r[0];
                st = !r[0];
            end
            if ($urandom_range(0, 9) < 8) begin
                f3 = ld ? load_codes[$urandom_range(0, 4)] : store_codes[$urandom_range(0, 2)];
            end else begin
                f3 = 3'($urandom);
            end
            applyStimulus(ld, st, f3, 32'($urandom_range(0, 63)), $urandom,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 32'd0);
        end

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

CPU-side initiator for the RV32 data memory. Accepts one load or store per request from the MEM stage, issues word-aligned accesses on the data-memory port (`{en,funct3}` read/write controls, `busywait`), extracts and sign/zero-extends sub-word load data, and implements SB/SH as a read-modify-write because the memory writes whole words only. Holds the pipeline via `busy` until the access completes.

## Interface
- `ADDR_W`, 32: byte-address width.
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  request present; sampled only in IDLE.
- `req_load` / `req_store`  in  1 each  access type; exactly one must be high with `req_valid`.
- `req_funct3`  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data (low bits used for SB/SH).
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result, valid while `done`.
- `err`  out  1  with `done`: misaligned/illegal request, no memory access made.
- `mem_read`  out  4  `{en, funct3}`; `4'b1010` when reading, else 0.
- `mem_write`  out  3  `{en, funct3[1:0]}`; `3'b110` when writing, else 0.
- `mem_address`  out  ADDR_W  always `{req_addr[31:2],2'b00}` of the latched request.
- `mem_writedata`  out  32  full (merged) word.
- `mem_readdata`  in  32  memory read word.
- `mem_busywait`  in  1  memory stall.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + `req_valid`: latch funct3/addr/wdata/type. Error check: LH/LHU/SH with `addr[0]=1`, LW/SW with `addr[1:0]≠0`, funct3 ∉ {000,001,010,100,101} for loads or ∉ {000,001,010} for stores, or load==store → DONE with `err=1`. Else load or SB/SH → READ; SW → WRITE.
- READ: drive `mem_read=4'b1010`. When `mem_busywait=0` at edge: capture `mem_readdata`; load → DONE, sub-word store → WRITE with merged word (SB: byte lane `addr[1:0]` ← `wdata[7:0]`; SH: half lane `addr[1]` ← `wdata[15:0]`; other lanes from captured word).
- WRITE: drive `mem_write=3'b110`, `mem_writedata`; leave to DONE at first edge with `mem_busywait=0` (memory commits on that edge).
- DONE: `done=1` one cycle, `rdata` = lane select by `addr[1:0]` then sign-extend (LB/LH) or zero-extend (LBU/LHU), LW passes word; → IDLE. Stores: `rdata=0`.
- Requester must drop or replace `req_valid` in the cycle after `done`; a still-high `req_valid` in IDLE starts a new access.
- `mem_read` and `mem_write` never both enabled.

## Timing
- Reset (async): state IDLE; `busy`,`done`,`err`=0; `rdata`,`mem_writedata`=0; `mem_read`=0, `mem_write`=0, `mem_address`=0. Reset mid-READ/WRITE aborts; no write issued after release.
- Latency from accepting edge to `done` high, no busywait: load 2 cycles, SW 2, SB/SH 3, error 1. Each busywait cycle in READ/WRITE adds one.
- `busy` rises the cycle after the accepting edge, falls with the DONE→IDLE edge.

## Structure
- Package `rv32_mem_pkg`: funct3 constants (LB..LHU, SB/SH/SW), `mem_read`/`mem_write` encodings, state enum.
- Sub-module `lsu_align`: combinational load extract/extend and store merge, shared by READ and DONE paths.

## Test plan
- Word 0x4 = 0x8899AABB; LB 0x5 → `rdata=0xFFFFFFAA`, `done` 2 cycles after accept; LBU 0x5 → 0x000000AA; LHU 0x6 → 0x00008899.
- SH 0x6, wdata 0x00001234 → one read then write of 0x1234AABB to address 0x4; LW 0x4 returns 0x1234AABB.
- SW 0x8 data 0xDEADBEEF → no read cycle, `mem_write=3'b110` one cycle, `done` at 2.
- LW 0x2 and SH 0x3 → `done`+`err` next cycle, `mem_read`/`mem_write` stay 0.
- `mem_busywait` high 3 cycles during READ of LB → `done` at 5, correct data.
- Reset asserted in WRITE of SB → outputs zero immediately, memory word unchanged, next request behaves normally.
